irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped interrupt controller sitting directly downstream of the Timer and other peripherals.
- Collects per-peripheral irq lines into a pending register, masks them with an enable register and resolves a fixed priority.
- Drives a single irq line to the CPU and runs a claim / end-of-interrupt (EOI) handshake.
- Uses the same 2-bit address, 16-bit data, chipselect/read_en/write_en bus as the Timer, so firmware drives both identically.

Parameters:
- NUM_SRC, 8, number of interrupt sources. Legal range is 1..16. Source 0 has the highest priority.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  reset. Asynchronous assert, active-low; clears all state.
- addr  input  2  register select.
- write_data  input  16  bus write data.
- write_en  input  1  write strobe, qualified by chipselect.
- read_en  input  1  read strobe, qualified by chipselect.
- chipselect  input  1  peripheral select.
- read_data  output  16  registered read data.
- irq_src  input  NUM_SRC  peripheral interrupt lines, synchronous to clk (e.g. Timer irq on bit 0).
- irq  output  1  interrupt request to the CPU, registered.

Behaviour:
- Memory map (bits at and above NUM_SRC read 0 and ignore writes):
  - 0: Pending. Read; write-1-to-clear.
  - 1: Enable. Read/write.
  - 2: Claim/EOI. Read returns {Valid, 11'h0, ID[3:0]}; write_data[3:0] is the EOI ID.
  - 3: Trigger mode. Read/write; 1 = rising edge, 0 = level.
- Reset values: all registers 0, state IDLE, irq 0, read_data 0.
- Edge detect: irq_src is registered once into src_q. Edge event = irq_src & ~src_q.
- Pending, edge-mode bits:
  - Set on an edge event.
  - Cleared by a W1C write to addr 0, or by a successful claim of that ID.
  - Set and clear in the same cycle: set wins.
- Pending, level-mode bits: equal to src_q. W1C and claim have no effect on them.
- Active vector = pending & enable. The winner is the lowest-index set bit, from a combinational priority encoder.
- Bus access:
  - An access occurs on a clock edge where chipselect=1 and the strobe is high.
  - read_data is loaded on that edge and is valid the cycle after read_en. It holds its value when no read occurs.
  - write_en and read_en together: both take effect, and read data reflects pre-write register values.
- FSM (registered irq = state==ASSERT):
  - IDLE:
    - Active vector non-zero -> ASSERT; irq rises 1 cycle later.
  - ASSERT:
    - Read of addr 2 -> latch winner ID into in_service_id. Return Valid=1 and that ID. Clear its pending bit if the source is edge-mode. Go to IN_SERVICE.
    - Active vector becomes 0 (W1C or disable) -> IDLE.
  - IN_SERVICE:
    - irq held 0; no nesting.
    - Write to addr 2 with write_data[3:0]==in_service_id -> IDLE.
    - EOI with a mismatched ID is ignored.
- Claim read outside ASSERT returns 16'h0000 with no state change.
- Disabling the in-service source does not end service; only EOI does.
- An edge arriving during IN_SERVICE is latched in pending and raises irq after EOI, via IDLE -> ASSERT.
- Reset mid-operation: immediate return to IDLE with irq 0; pending history is lost.

Decomposition:
- Package irqc_pkg:
  - Address constants ADDR_PENDING=0, ADDR_ENABLE=1, ADDR_CLAIM=2, ADDR_TRIG=3.
  - State enum irqc_state_t {IDLE, ASSERT, IN_SERVICE}.
  - CLAIM_VALID_BIT=15.
- Sub-module irqc_prio_enc: NUM_SRC-wide combinational priority encoder with outputs {any, id[3:0]}.

Test Plan:
- Reset, then read all four addresses -> every read_data is 16'h0000 and irq stays 0.
- Write Trig=0x0001, Enable=0x0001, then pulse irq_src[0] for 1 cycle -> Pending reads 0x0001 and irq=1 within 2 cycles. Claim read returns 0x8000 and irq drops. EOI write 0x0000 -> state IDLE and Pending=0x0000.
- Edge mode, Enable=0x00FF, pulse bits 5 and 2 in the same cycle -> first claim returns 0x8002. After EOI 2, irq re-asserts and the second claim returns 0x8005.
- Level mode on bit 3, Enable=0x0008, hold irq_src[3]=1 -> claim returns 0x8003. W1C 0x0008 leaves Pending=0x0008. After EOI, irq re-asserts until irq_src[3] falls.
- In IN_SERVICE for ID 1, write EOI 0x0004 -> ignored and irq stays 0. A following EOI 0x0001 returns to IDLE.
- Assert reset_n=0 while in ASSERT -> irq 0 asynchronously. After release, all registers read 0x0000.

Source files
------------

// File: rtl/irqc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irqc_pkg : shared constants and state type for the interrupt controller
// Rev 1.0
// ---------------------------------------------------------------------------
package irqc_pkg;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;
  localparam logic [1:0] ADDR_TRIG    = 2'd3;

  localparam int CLAIM_VALID_BIT = 15;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    IN_SERVICE = 2'd2
  } irqc_state_t;

endpackage
`default_nettype wire

// File: rtl/irqc_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irqc_prio_enc : fixed-priority encoder, lowest set index wins
// Rev 1.0
// ---------------------------------------------------------------------------
module irqc_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               any,
  output logic [3:0]         id
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    any = 1'b0;
    id  = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any = 1'b1;
        id  = 4'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_controller : pending/enable/trigger registers, priority and claim/EOI
// Rev 1.0
// ---------------------------------------------------------------------------
module irq_controller
  import irqc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         addr,
  input  logic [15:0]        write_data,
  input  logic               write_en,
  input  logic               read_en,
  input  logic               chipselect,
  output logic [15:0]        read_data,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq
);

  irqc_state_t        state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pend_edge;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] trig;
  logic [3:0]         in_service_id;

  logic               rd_acc;
  logic               wr_acc;
  logic [NUM_SRC-1:0] edge_ev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] pend_next;
  logic               win_any;
  logic [3:0]         win_id;
  logic               claim_ok;
  logic               eoi_ok;
  logic [15:0]        claim_word;
  logic [15:0]        rd_mux;
  logic               unused_wd;

  // Upper write_data bits only matter for wide configurations.
  assign unused_wd = ^write_data;

  assign rd_acc  = chipselect & read_en;
  assign wr_acc  = chipselect & write_en;
  assign edge_ev = irq_src & ~src_q;

  // Level sources mirror the synchronised line; edge sources use the latch.
  assign pending = (pend_edge & trig) | (src_q & ~trig);
  assign active  = pending & enable;

  irqc_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .vec (active),
    .any (win_any),
    .id  (win_id)
  );

  assign claim_ok  = rd_acc && (addr == ADDR_CLAIM) && (state == ASSERT) && win_any;
  assign eoi_ok    = wr_acc && (addr == ADDR_CLAIM) && (write_data[3:0] == in_service_id);
  assign w1c       = (wr_acc && (addr == ADDR_PENDING)) ? write_data[NUM_SRC-1:0] : '0;
  assign claim_clr = claim_ok ? (NUM_SRC'(1) << win_id) : '0;
  // A new edge in the same cycle as a clear keeps the bit set.
  assign pend_next = ((pend_edge & ~(w1c | claim_clr)) | edge_ev) & trig;

  always_comb begin
    claim_word                  = 16'h0000;
    claim_word[CLAIM_VALID_BIT] = 1'b1;
    claim_word[3:0]             = win_id;
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (addr)
      ADDR_PENDING: rd_mux = 16'(pending);
      ADDR_ENABLE:  rd_mux = 16'(enable);
      ADDR_CLAIM:   rd_mux = claim_ok ? claim_word : 16'h0000;
      ADDR_TRIG:    rd_mux = 16'(trig);
      default:      rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      irq           <= 1'b0;
      in_service_id <= 4'd0;
      read_data     <= 16'h0000;
      src_q         <= '0;
      pend_edge     <= '0;
      enable        <= '0;
      trig          <= '0;
    end else begin
      src_q     <= irq_src;
      pend_edge <= pend_next;

      if (wr_acc && (addr == ADDR_ENABLE)) enable <= write_data[NUM_SRC-1:0];
      if (wr_acc && (addr == ADDR_TRIG))   trig   <= write_data[NUM_SRC-1:0];
      if (rd_acc)                          read_data <= rd_mux;

      case (state)
        IDLE: begin
          if (win_any) begin
            state <= ASSERT;
            irq   <= 1'b1;
          end
        end
        ASSERT: begin
          if (claim_ok) begin
            state         <= IN_SERVICE;
            in_service_id <= win_id;
            irq           <= 1'b0;
          end else if (!win_any) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        IN_SERVICE: begin
          if (eoi_ok) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_irq_controller : directed vectors for irq_controller
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] write_data = 16'h0000;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic        chipselect = 1'b0;
  logic [15:0] read_data;
  logic [7:0]  irq_src = 8'h00;
  logic        irq;

  int checks = 0;
  int passes = 0;

  irq_controller #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .addr       (addr),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .chipselect (chipselect),
    .read_data  (read_data),
    .irq_src    (irq_src),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_en = 1'b1; addr = a; write_data = d;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_en = 1'b1; addr = a;
    @(negedge clk);
    chipselect = 1'b0; read_en = 1'b0;
    d = read_data;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic pulse(input logic [7:0] bits);
    @(negedge clk);
    irq_src = irq_src | bits;
    @(negedge clk);
    irq_src = irq_src & ~bits;
  endtask

  task automatic wait_irq(input string tag, input logic val, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (irq === val) break;
      @(negedge clk);
    end
    check(tag, {15'h0, irq}, {15'h0, val});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle_cycles(3);
    reset_n = 1'b1;
    check("reset_irq", {15'h0, irq}, 16'h0000);
    read_check("reset_pending", 2'd0, 16'h0000);
    read_check("reset_enable",  2'd1, 16'h0000);
    read_check("reset_claim",   2'd2, 16'h0000);
    read_check("reset_trig",    2'd3, 16'h0000);
    check("reset_irq_after", {15'h0, irq}, 16'h0000);

    // Bits above NUM_SRC read zero; simultaneous read+write returns old value
    @(negedge clk);
    chipselect = 1'b1; write_en = 1'b1; read_en = 1'b1; addr = 2'd1; write_data = 16'hFFFF;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0; read_en = 1'b0;
    check("rw_pre_value", read_data, 16'h0000);
    read_check("enable_width", 2'd1, 16'h00FF);
    bus_write(2'd1, 16'h0000);

    // Single edge source, claim and EOI
    bus_write(2'd3, 16'h0001);
    bus_write(2'd1, 16'h0001);
    pulse(8'h01);
    wait_irq("edge0_irq", 1'b1, 3);
    read_check("edge0_pending", 2'd0, 16'h0001);
    read_check("edge0_claim", 2'd2, 16'h8000);
    check("edge0_irq_drop", {15'h0, irq}, 16'h0000);
    read_check("edge0_pend_clr", 2'd0, 16'h0000);
    bus_write(2'd2, 16'h0000);
    idle_cycles(2);
    check("edge0_idle_irq", {15'h0, irq}, 16'h0000);
    read_check("edge0_idle_claim", 2'd2, 16'h0000);

    // Two simultaneous edges resolved by priority
    bus_write(2'd3, 16'h00FF);
    bus_write(2'd1, 16'h00FF);
    pulse(8'h24);
    wait_irq("prio_irq1", 1'b1, 4);
    read_check("prio_claim1", 2'd2, 16'h8002);
    read_check("prio_pending", 2'd0, 16'h0020);
    bus_write(2'd2, 16'h0002);
    wait_irq("prio_irq2", 1'b1, 4);
    read_check("prio_claim2", 2'd2, 16'h8005);
    bus_write(2'd2, 16'h0005);
    idle_cycles(2);
    read_check("prio_pend_empty", 2'd0, 16'h0000);
    check("prio_irq_low", {15'h0, irq}, 16'h0000);

    // Level source ignores W1C and claim clearing
    bus_write(2'd3, 16'h0000);
    bus_write(2'd1, 16'h0008);
    @(negedge clk);
    irq_src = 8'h08;
    wait_irq("lvl_irq", 1'b1, 4);
    read_check("lvl_claim", 2'd2, 16'h8003);
    bus_write(2'd0, 16'h0008);
    read_check("lvl_w1c", 2'd0, 16'h0008);
    bus_write(2'd2, 16'h0003);
    wait_irq("lvl_reassert", 1'b1, 4);
    @(negedge clk);
    irq_src = 8'h00;
    wait_irq("lvl_fall", 1'b0, 4);
    read_check("lvl_pend_clear", 2'd0, 16'h0000);

    // Mismatched EOI ignored; edge during service raises irq after EOI
    bus_write(2'd3, 16'h0002);
    bus_write(2'd1, 16'h0002);
    pulse(8'h02);
    wait_irq("eoi_irq", 1'b1, 4);
    read_check("eoi_claim", 2'd2, 16'h8001);
    pulse(8'h02);
    bus_write(2'd2, 16'h0004);
    idle_cycles(3);
    check("eoi_bad_irq", {15'h0, irq}, 16'h0000);
    read_check("eoi_bad_claim", 2'd2, 16'h0000);
    read_check("eoi_latched", 2'd0, 16'h0002);
    bus_write(2'd2, 16'h0001);
    wait_irq("eoi_good_reassert", 1'b1, 4);

    // Asynchronous reset while in ASSERT
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", {15'h0, irq}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    read_check("post_rst_pending", 2'd0, 16'h0000);
    read_check("post_rst_enable",  2'd1, 16'h0000);
    read_check("post_rst_claim",   2'd2, 16'h0000);
    read_check("post_rst_trig",    2'd3, 16'h0000);
    check("post_rst_irq", {15'h0, irq}, 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
